enigma_stream_buffer: RTL
=========================

// Module: enigma_stream_buffer
// PURPOSE
//  Parametrised frame buffer between the external symbol stream and the enigma core.
//  - Collects a frame of N valid letter codes (1..26) into an input RAM.
//  - Feeds the frame to the core back-to-back.
//  - Captures the core's encoded results, at arbitrary core latency, into an output RAM.
//  - Drains the results to the consumer with a valid/ready handshake.
// PARAMETERS
//  SYMB_W  6   symbol width; letter codes 1..26, all other values invalid
//  DEPTH   16  max symbols per frame (input and output RAM depth)
//  CNT_W   $clog2(DEPTH+1)  frame counter/address width, derived, not overridden
// PORTS
//  clk_i            in   1       single clock, rising edge
//  rst_i            in   1       reset, synchronous, active-high
//  start_i          in   1       begin frame; sampled in IDLE only
//  symb_numb_i      in   CNT_W   frame length N; sampled with start_i
//  wrap_valid_i     in   1       input symbol valid
//  wrap_i           in   SYMB_W  input symbol
//  wrap_ready_o     out  1       buffer accepts input (FILL state)
//  in_en_valid_o    out  1       symbol to core valid
//  in_en_o          out  SYMB_W  symbol to core
//  out_en_valid_i   in   1       encoded symbol from core valid
//  out_en_i         in   SYMB_W  encoded symbol from core
//  wrap_valid_o     out  1       output symbol valid
//  wrap_o           out  SYMB_W  output symbol
//  wrap_ready_i     in   1       consumer accepts output
//  busy_o           out  1       state != IDLE
//  done_o           out  1       1-cycle pulse: last output symbol accepted
//  err_o            out  1       1-cycle pulse: invalid/dropped event (see below)
// BEHAVIOUR
//  Reset: rst_i=1 at a clock edge forces the following, from any state, mid-frame included:
//   - state=IDLE.
//   - All counters 0.
//   - All outputs 0.
//   - RAM contents are not cleared; they are don't-care.
//  FSM: IDLE -> FILL -> FEED -> WAIT -> DRAIN -> IDLE.
//  IDLE: start_i=1 latches N=symb_numb_i.
//   - N=0: ignored, stay IDLE, err_o.
//   - N>DEPTH: N clamped to DEPTH, err_o, enter FILL.
//  FILL: wrap_ready_o=1.
//   - Handshake wrap_valid_i & wrap_ready_o with wrap_i in 1..26: write in_mem[wr_ad], wr_ad+1.
//   - Valid with wrap_i=0 or >26: symbol dropped, no write, err_o.
//   - Cycle after the N-th write: FEED; wrap_ready_o=0 from that cycle.
//  FEED: rd_ad steps 0..N-1, one per cycle, no stalls.
//   - in_en_o/in_en_valid_o are registered and valid for N consecutive cycles,
//     starting the cycle after FEED entry. Then FEED -> WAIT.
//   - in_en_valid_o=0 and in_en_o holds 0 outside these cycles.
//  Capture: in FEED and WAIT, each out_en_valid_i=1 writes out_mem[ow_ad], ow_ad+1.
//   - The core may return results during FEED.
//   - Results with out_en_i outside 1..26 are stored as-is and flagged by err_o.
//   - When ow_ad reaches N: DRAIN next cycle.
//   - out_en_valid_i in IDLE/FILL/DRAIN: ignored, err_o.
//  DRAIN: wrap_valid_o=1, wrap_o=out_mem[dr_ad], both registered.
//   - Transfer on wrap_valid_o & wrap_ready_i, then dr_ad+1.
//   - wrap_ready_i=0: wrap_o and wrap_valid_o held stable.
//   - On the N-th transfer: done_o pulses in the same cycle; IDLE next cycle; wrap_valid_o=0.
//  Simultaneous events:
//   - start_i outside IDLE is ignored, no error.
//   - Two error causes in one cycle give a single err_o pulse.
//  Widths and counters:
//   - All counters are CNT_W wide.
//   - N=DEPTH must not wrap: compare with ==N, never overflow-detect.
//  Min frame latency, N symbols, ready always 1, core latency L:
//   - first wrap_valid_o at or after (N fill) + 1 + L + 1 cycles.
// TESTING
//  T1 N=4, input 8,5,12,16, core = +1 after 2 cycles -> in_en_o 8,5,12,16 on 4 consecutive cycles.
//     Then wrap_o 9,6,13,17 and a done_o pulse.
//  T2 N=3, input 3,0,27,7,9 -> only 3,7,9 written; err_o pulses twice; FEED sends 3,7,9.
//  T3 N=DEPTH=16, wrap_ready_i toggled 1,0,0,1... -> 16 outputs in order, none duplicated or lost.
//     wrap_o stable while ready=0; done_o once.
//  T4 symb_numb_i=20 -> clamp to 16, err_o pulse; symb_numb_i=0 -> stays IDLE, err_o.
//  T5 rst_i=1 in FEED after 2 symbols -> next cycle IDLE, all outputs 0, busy_o=0.
//     A new frame N=2 with 1,26 then completes correctly.
//  T6 out_en_valid_i during FILL -> ignored, err_o; the frame result is unaffected.

Source files
------------

// File: rtl/enigma_stream_buffer.sv
// Frame buffer between the external symbol stream and the enigma core:
// collect N letters, feed them back-to-back, capture core results, drain them.
module enigma_stream_buffer #(
    parameter int SYMB_W = 6,
    parameter int DEPTH  = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  symb_numb_i,
    input  logic              wrap_valid_i,
    input  logic [SYMB_W-1:0] wrap_i,
    output logic              wrap_ready_o,
    output logic              in_en_valid_o,
    output logic [SYMB_W-1:0] in_en_o,
    input  logic              out_en_valid_i,
    input  logic [SYMB_W-1:0] out_en_i,
    output logic              wrap_valid_o,
    output logic [SYMB_W-1:0] wrap_o,
    input  logic              wrap_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int AD_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SYMB_W-1:0] LETTER_MAX = SYMB_W'(26);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_FEED, S_WAIT, S_DRAIN} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  n_reg;
    logic [CNT_W-1:0]  wr_ad_reg;
    logic [CNT_W-1:0]  rd_ad_reg;
    logic [CNT_W-1:0]  ow_ad_reg;
    logic [CNT_W-1:0]  dr_ad_reg;

    logic [SYMB_W-1:0] in_mem  [DEPTH];
    logic [SYMB_W-1:0] out_mem [DEPTH];

    function automatic logic is_letter(input logic [SYMB_W-1:0] s);
        return (s != '0) && (s <= LETTER_MAX);
    endfunction

    logic             in_fire;
    logic             in_wr;
    logic             cap_wr;
    logic             dr_xfer;
    logic             err_next;
    logic [CNT_W-1:0] n_last;
    logic [AD_W-1:0]  dr_rd_ad;

    assign n_last   = n_reg - 1'b1;
    assign in_fire  = (state_reg == S_FILL) && wrap_valid_i;
    assign in_wr    = in_fire && is_letter(wrap_i);
    assign cap_wr   = ((state_reg == S_FEED) || (state_reg == S_WAIT)) && out_en_valid_i;
    assign dr_xfer  = (state_reg == S_DRAIN) && wrap_valid_o && wrap_ready_i;
    // While a symbol is presented, prefetch the one after it so a transfer never bubbles.
    assign dr_rd_ad = dr_ad_reg[AD_W-1:0] + AD_W'(wrap_valid_o);

    assign err_next = ((state_reg == S_IDLE) && start_i &&
                       ((symb_numb_i == '0) || (symb_numb_i > CNT_W'(DEPTH))))
                    || (in_fire && !is_letter(wrap_i))
                    || (out_en_valid_i && (state_reg != S_FEED) && (state_reg != S_WAIT))
                    || (cap_wr && !is_letter(out_en_i));

    assign wrap_ready_o = (state_reg == S_FILL);
    assign busy_o       = (state_reg != S_IDLE);
    assign done_o       = dr_xfer && (dr_ad_reg == n_last);

    always_ff @(posedge clk_i) begin
        if (in_wr)
            in_mem[wr_ad_reg[AD_W-1:0]] <= wrap_i;
        if (cap_wr)
            out_mem[ow_ad_reg[AD_W-1:0]] <= out_en_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= S_IDLE;
            n_reg         <= '0;
            wr_ad_reg     <= '0;
            rd_ad_reg     <= '0;
            ow_ad_reg     <= '0;
            dr_ad_reg     <= '0;
            in_en_valid_o <= 1'b0;
            in_en_o       <= '0;
            wrap_valid_o  <= 1'b0;
            wrap_o        <= '0;
            err_o         <= 1'b0;
        end else begin
            err_o         <= err_next;
            in_en_valid_o <= 1'b0;
            in_en_o       <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (start_i && (symb_numb_i != '0)) begin
                        n_reg     <= (symb_numb_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : symb_numb_i;
                        wr_ad_reg <= '0;
                        state_reg <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (in_wr) begin
                        wr_ad_reg <= wr_ad_reg + 1'b1;
                        if (wr_ad_reg == n_last) begin
                            rd_ad_reg <= '0;
                            ow_ad_reg <= '0;
                            state_reg <= S_FEED;
                        end
                    end
                end
                S_FEED: begin
                    in_en_valid_o <= 1'b1;
                    in_en_o       <= in_mem[rd_ad_reg[AD_W-1:0]];
                    if (rd_ad_reg == n_last)
                        state_reg <= S_WAIT;
                    else
                        rd_ad_reg <= rd_ad_reg + 1'b1;
                end
                S_WAIT: begin
                end
                S_DRAIN: begin
                    if (!wrap_valid_o) begin
                        wrap_o       <= out_mem[dr_rd_ad];
                        wrap_valid_o <= 1'b1;
                    end else if (wrap_ready_i) begin
                        if (dr_ad_reg == n_last) begin
                            wrap_valid_o <= 1'b0;
                            wrap_o       <= '0;
                            state_reg    <= S_IDLE;
                        end else begin
                            wrap_o    <= out_mem[dr_rd_ad];
                            dr_ad_reg <= dr_ad_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
            // Capture may complete while still feeding; it takes priority over FEED/WAIT moves.
            if (cap_wr) begin
                ow_ad_reg <= ow_ad_reg + 1'b1;
                if (ow_ad_reg == n_last) begin
                    dr_ad_reg <= '0;
                    state_reg <= S_DRAIN;
                end
            end
        end
    end

endmodule
